gcd_ctrl: RTL and testbench

- Moore-style controller that sequences the 32-bit GCD datapath: two load-enabled parallel-in/parallel-out operand registers A and B, an input mux, an operand-select subtractor and a magnitude comparator.
- Runs the start/load/compare/subtract loop (repeated subtraction of the smaller operand from the larger) and drives the register load enables and mux selects.
- Signals completion or a runaway-iteration abort.
- Sits between the top-level command interface and the datapath.

---
 rtl/gcd_ctrl.sv | 177 +++++++++++++++++
 tb/tb_gcd_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_ctrl.sv
// gcd_ctrl: Moore controller sequencing the 32-bit subtract-based GCD datapath.
// Loads A then B from the external input, loops compare/subtract until the
// comparator reports equality, and aborts after MAX_ITER subtract steps.
module gcd_ctrl #(
    parameter int unsigned MAX_ITER = 1000,
    parameter int unsigned CW       = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          lt,
    input  logic          gt,
    input  logic          eq,
    output logic          lda,
    output logic          ldb,
    output logic          sel_in,
    output logic          sel1,
    output logic          sel2,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [CW-1:0] iter
);

    localparam int unsigned STATE_W = 3;
    localparam logic [CW-1:0] MAX_ITER_C = CW'(MAX_ITER);

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD_A  = 3'd1,
        ST_LOAD_B  = 3'd2,
        ST_COMPARE = 3'd3,
        ST_SUB_A   = 3'd4,
        ST_SUB_B   = 3'd5,
        ST_DONE    = 3'd6,
        ST_ERR     = 3'd7
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] iter_q,  iter_d;

    logic lda_q,    lda_d;
    logic ldb_q,    ldb_d;
    logic sel_in_q, sel_in_d;
    logic sel1_q,   sel1_d;
    logic sel2_q,   sel2_d;
    logic busy_q,   busy_d;
    logic done_q,   done_d;
    logic err_q,    err_d;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; comparator flags resolved with eq > lt > gt priority
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD_A;
                end
            end
            ST_LOAD_A:  state_d = ST_LOAD_B;
            ST_LOAD_B:  state_d = ST_COMPARE;
            ST_COMPARE: begin
                if (eq) begin
                    state_d = ST_DONE;
                end else if (iter_q == MAX_ITER_C) begin
                    state_d = ST_ERR;
                end else if (lt) begin
                    state_d = ST_SUB_B;
                end else if (gt) begin
                    state_d = ST_SUB_A;
                end else begin
                    state_d = ST_ERR;
                end
            end
            ST_SUB_A:   state_d = ST_COMPARE;
            ST_SUB_B:   state_d = ST_COMPARE;
            ST_DONE:    state_d = ST_IDLE;
            ST_ERR:     state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Output decode of the upcoming state, so the registered outputs track state_q
    always_comb begin
        lda_d    = 1'b0;
        ldb_d    = 1'b0;
        sel_in_d = 1'b0;
        sel1_d   = 1'b0;
        sel2_d   = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        iter_d   = iter_q;
        unique case (state_d)
            ST_LOAD_A: begin
                lda_d    = 1'b1;
                sel_in_d = 1'b1;
                busy_d   = 1'b1;
                iter_d   = '0;
            end
            ST_LOAD_B: begin
                ldb_d    = 1'b1;
                sel_in_d = 1'b1;
                busy_d   = 1'b1;
            end
            ST_COMPARE: begin
                busy_d = 1'b1;
            end
            ST_SUB_A: begin
                lda_d  = 1'b1;
                sel2_d = 1'b1;
                busy_d = 1'b1;
                iter_d = iter_q + CW'(1);
            end
            ST_SUB_B: begin
                ldb_d  = 1'b1;
                sel1_d = 1'b1;
                busy_d = 1'b1;
                iter_d = iter_q + CW'(1);
            end
            ST_DONE: begin
                done_d = 1'b1;
            end
            ST_ERR: begin
                err_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // Output and iteration-counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lda_q    <= 1'b0;
            ldb_q    <= 1'b0;
            sel_in_q <= 1'b0;
            sel1_q   <= 1'b0;
            sel2_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            iter_q   <= '0;
        end else begin
            lda_q    <= lda_d;
            ldb_q    <= ldb_d;
            sel_in_q <= sel_in_d;
            sel1_q   <= sel1_d;
            sel2_q   <= sel2_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            iter_q   <= iter_d;
        end
    end

    assign lda    = lda_q;
    assign ldb    = ldb_q;
    assign sel_in = sel_in_q;
    assign sel1   = sel1_q;
    assign sel2   = sel2_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;
    assign iter   = iter_q;

endmodule

// File: tb/tb_gcd_ctrl.sv
// tb_gcd_ctrl: behavioural datapath around gcd_ctrl plus a scoreboard that
// compares each completed run against an arithmetic GCD reference.
module tb_gcd_ctrl;

    localparam int unsigned MAX_ITER = 12;
    localparam int unsigned CW       = 16;
    localparam int          DRAIN_LIMIT = 200;

    logic          clk = 1'b0;
    logic          rst_n, start, lt, gt, eq;
    logic          lda, ldb, sel_in, sel1, sel2, busy, done, err;
    logic [CW-1:0] iter;

    logic [31:0] op_a, op_b, ra, rb, sub_v;
    int          mode;  // 0: real comparator, 1: no flag, 2: lt and gt both set

    typedef struct {
        bit          is_err;
        logic [31:0] res;
        int          n;
    } exp_t;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    gcd_ctrl #(.MAX_ITER(MAX_ITER), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .lt(lt), .gt(gt), .eq(eq),
        .lda(lda), .ldb(ldb), .sel_in(sel_in), .sel1(sel1), .sel2(sel2),
        .busy(busy), .done(done), .err(err), .iter(iter)
    );

    // Datapath: operand registers, input mux, operand-select subtractor, comparator
    assign sub_v = (sel1 ? rb : ra) - (sel2 ? rb : ra);
    assign eq = (mode == 0) ? (ra == rb) : 1'b0;
    assign lt = (mode == 0) ? (ra <  rb) : (mode == 2);
    assign gt = (mode == 0) ? (ra >  rb) : (mode == 2);

    always @(posedge clk) begin
        if (lda) ra <= sel_in ? op_a : sub_v;
        if (ldb) rb <= sel_in ? op_b : sub_v;
    end

    task automatic chk(input string name, input longint act, input longint expv);
        n_vec++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Reference: repeated subtraction of smaller from larger, capped at MAX_ITER steps
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [31:0] x, y;
        x = a; y = b;
        e.is_err = 1'b1; e.res = '0; e.n = MAX_ITER;
        for (int s = 0; s <= MAX_ITER; s++) begin
            if (x == y) begin
                e.is_err = 1'b0; e.res = x; e.n = s;
                break;
            end
            if (s == MAX_ITER) break;
            if (x < y) y = y - x;
            else       x = x - y;
        end
        return e;
    endfunction

    // Monitor: pops an expectation on every done/err pulse
    initial begin : monitor
        int   busy_cnt;
        bit   prev_busy;
        exp_t e;
        busy_cnt  = 0;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_cnt  = 0;
                prev_busy = 1'b0;
            end else begin
                if (busy && !prev_busy) busy_cnt = 0;
                if (busy) busy_cnt++;
                if (done || err) begin
                    if (q.size() == 0) begin
                        chk("unexpected_end", 1, 0);
                    end else begin
                        e = q.pop_front();
                        chk("err_flag", err, e.is_err);
                        chk("done_flag", done, !e.is_err);
                        chk("iter", iter, e.n);
                        chk("busy_len", busy_cnt, 3 + 2 * e.n);
                        chk("end_follows_busy", prev_busy, 1);
                        chk("busy_at_end", busy, 0);
                        if (!e.is_err) begin
                            chk("result_a", ra, e.res);
                            chk("result_b", rb, e.res);
                        end
                    end
                end
                prev_busy = busy;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int k = 0;
        while (q.size() != 0 && k < DRAIN_LIMIT) begin
            @(posedge clk);
            k++;
        end
        if (q.size() != 0) begin
            chk("drain_timeout", q.size(), 0);
            q.delete();
        end
        tick(2);
    endtask

    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        op_a = a; op_b = b;
        q.push_back(model(a, b));
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic run(input logic [31:0] a, input logic [31:0] b);
        launch(a, b);
        drain();
    endtask

    initial begin : stim
        exp_t e;
        int   k;
        rst_n = 1'b0; start = 1'b0; mode = 0; op_a = '0; op_b = '0;
        tick(2);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_iter", iter, 0);
        rst_n = 1'b1;
        tick(1);

        // Directed runs
        run(32'd12, 32'd8);
        run(32'd7,  32'd7);
        run(32'd5,  32'd0);
        run(32'd0,  32'd0);

        // No flag at first COMPARE aborts immediately
        mode = 1;
        op_a = 32'd3; op_b = 32'd4;
        e.is_err = 1'b1; e.res = '0; e.n = 0;
        q.push_back(e);
        start = 1'b1; tick(1); start = 1'b0;
        drain();

        // lt and gt together: SUB_B chosen in cycle 4, never converges
        mode = 2;
        e.is_err = 1'b1; e.res = '0; e.n = MAX_ITER;
        q.push_back(e);
        start = 1'b1; tick(1); start = 1'b0;
        tick(3);
        chk("prio_ldb", ldb, 1);
        chk("prio_lda", lda, 0);
        chk("prio_sel1", sel1, 1);
        chk("prio_sel2", sel2, 0);
        drain();
        mode = 0;

        // Reset in cycle 5 of a run
        op_a = 32'd12; op_b = 32'd8;
        start = 1'b1; tick(1); start = 1'b0;
        tick(3);
        rst_n = 1'b0;
        tick(1);
        chk("mid_rst_lda", lda, 0);
        chk("mid_rst_ldb", ldb, 0);
        chk("mid_rst_selin", sel_in, 0);
        chk("mid_rst_sel1", sel1, 0);
        chk("mid_rst_sel2", sel2, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_iter", iter, 0);
        rst_n = 1'b1;
        tick(1);
        run(32'd12, 32'd8);

        // start re-pulsed during cycles 3-6 is ignored
        launch(32'd12, 32'd8);
        tick(1);
        start = 1'b1;
        tick(4);
        start = 1'b0;
        drain();

        // start held high through DONE re-launches right after IDLE
        op_a = 32'd12; op_b = 32'd8;
        q.push_back(model(32'd12, 32'd8));
        start = 1'b1;
        tick(1);
        k = 0;
        while (!done && k < DRAIN_LIMIT) begin
            tick(1);
            k++;
        end
        chk("hold_done_seen", done, 1);
        op_a = 32'd9; op_b = 32'd6;
        q.push_back(model(32'd9, 32'd6));
        tick(1);
        chk("hold_idle_busy", busy, 0);
        chk("hold_idle_lda", lda, 0);
        tick(1);
        chk("hold_relaunch_lda", lda, 1);
        chk("hold_relaunch_selin", sel_in, 1);
        start = 1'b0;
        drain();

        // Randomized runs
        for (int i = 0; i < 40; i++) begin
            run(32'($urandom_range(0, 20)), 32'($urandom_range(0, 20)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
